// File: rtl/layer_serializer.sv
// Gathers one parallel layer's neuron outputs and replays them as a gap-free serial stream,
// neuron 0 first, flagging any word that arrives while the previous layer is unconsumed.
module layer_serializer #(
  parameter int unsigned numNeurons = 30,
  parameter int unsigned dataWidth  = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [numNeurons-1:0]             i_in_valid,
  input  logic [numNeurons*dataWidth-1:0]   i_in_data,
  output logic                              o_out_valid,
  output logic [dataWidth-1:0]              o_out_data,
  output logic                              o_out_last,
  output logic                              o_busy,
  output logic                              o_overrun
);

  localparam int unsigned IdxW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(numNeurons - 1);

  typedef enum logic {StCollect, StSend} state_e;

  state_e                r_state;
  logic [numNeurons-1:0] r_captured;
  logic [IdxW-1:0]       r_idx;
  logic [dataWidth-1:0]  r_buf [numNeurons];

  logic [numNeurons-1:0] w_all_seen;
  assign w_all_seen = r_captured | i_in_valid;

  assign o_busy = (r_state == StSend);

  // Word storage carries no reset; it is only meaningful once its captured bit is set.
  always_ff @(posedge i_clk) begin
    if (!i_rst && r_state == StCollect) begin
      for (int k = 0; k < int'(numNeurons); k++) begin
        if (i_in_valid[k]) r_buf[k] <= i_in_data[k*dataWidth +: dataWidth];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StCollect;
      r_captured  <= '0;
      r_idx       <= '0;
      o_out_valid <= 1'b0;
      o_out_last  <= 1'b0;
      o_out_data  <= '0;
      o_overrun   <= 1'b0;
    end else begin
      o_out_valid <= 1'b0;
      o_out_last  <= 1'b0;
      unique case (r_state)
        StCollect: begin
          r_captured <= w_all_seen;
          if (|(r_captured & i_in_valid)) o_overrun <= 1'b1;
          if (&w_all_seen) begin
            r_state <= StSend;
            r_idx   <= '0;
          end
        end
        StSend: begin
          // Inputs arriving mid-stream are dropped but still reported.
          if (|i_in_valid) o_overrun <= 1'b1;
          o_out_valid <= 1'b1;
          o_out_data  <= r_buf[r_idx];
          o_out_last  <= (r_idx == LastIdx);
          if (r_idx != LastIdx) begin
            r_idx <= r_idx + 1'b1;
          end else begin
            r_state    <= StCollect;
            r_captured <= '0;
            r_idx      <= '0;
          end
        end
        default: r_state <= StCollect;
      endcase
    end
  end

endmodule
